// File: rtl/game_over_overlay_pkg.sv
// Shared constants and types for the game-over text overlay stage.
package game_over_overlay_pkg;

  // Screen geometry of the VGA chain this stage sits in.
  localparam int HOR_PIX = 1024;
  localparam int VER_PIX = 768;

  // Font cell and on-screen scaling.
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int SCALE  = 2;

  // Message geometry: 9 cells of 16x32 pixels form a 144x32 box.
  localparam int TEXT_LEN = 9;
  localparam int BOX_W    = TEXT_LEN * CHAR_W * SCALE;
  localparam int BOX_H    = CHAR_H * SCALE;

  // Datapath widths.
  localparam int COORD_W     = 11;
  localparam int RGB_W       = 12;
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;
  localparam int FRAME_CNT_W = 6;

  typedef logic [6:0] char_code_t;

  // "GAME OVER", character 0 in the least significant slot.
  localparam logic [TEXT_LEN-1:0][6:0] TEXT_CODES = {
    7'h52, 7'h45, 7'h56, 7'h4F, 7'h20, 7'h45, 7'h4D, 7'h41, 7'h47
  };

  // Timing bundle that travels alongside the pixel through the pipeline.
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               hblnk;
    logic               vsync;
    logic               vblnk;
  } vga_timing_t;

endpackage

// File: rtl/game_over_overlay_font_rom.sv
// Glyph ROM for the characters of the game-over message.
// Address is {code[6:0], row[3:0]}; one registered read per clock; bit 7 is
// the leftmost pixel. Each 8x8 source bitmap row is repeated for two font
// rows to fill the 8x16 cell; codes without a glyph read as blank.
module game_over_font_rom
  import game_over_overlay_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FONT_ADDR_W-1:0] addr,
  output logic [FONT_DATA_W-1:0] data
);

  function automatic logic [FONT_DATA_W-1:0] glyph_row(input char_code_t code,
                                                       input logic [3:0] row);
    logic [63:0] bm;
    case (code)
      7'h47:   bm = 64'h3C66C0C0CE663E00; // G
      7'h41:   bm = 64'h3078CCCCFCCCCC00; // A
      7'h4D:   bm = 64'hC6EEFEFED6C6C600; // M
      7'h45:   bm = 64'hFE6268786862FE00; // E
      7'h4F:   bm = 64'h386CC6C6C66C3800; // O
      7'h56:   bm = 64'hCCCCCCCCCC783000; // V
      7'h52:   bm = 64'hFC66667C6C66E600; // R
      default: bm = 64'h0;                // space and everything else
    endcase
    // Bitmap row 0 lives in the top byte.
    return bm[{~row[3:1], 3'b111} -: 8];
  endfunction

  // Registered read keeps the ROM output aligned with the first pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= glyph_row(addr[10:4], addr[3:0]);
  end

endmodule

// File: rtl/game_over_overlay.sv
// Game-over text overlay: composites a blinking "GAME OVER" box onto the
// upstream VGA pixel stream with a fixed two-clock latency.
module game_over_overlay
  import game_over_overlay_pkg::*;
#(
  parameter int               TEXT_X    = 440,
  parameter int               TEXT_Y    = 368,
  parameter logic [RGB_W-1:0] TEXT_RGB  = 12'hF00,
  parameter int               BLINK_BIT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic               game_over,
  input  logic               restart,
  output logic [COORD_W-1:0] hcount_out,
  output logic [COORD_W-1:0] vcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               overlay_active
);

  localparam logic [COORD_W-1:0] X_LO = COORD_W'(TEXT_X);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(TEXT_X + BOX_W);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(TEXT_Y);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(TEXT_Y + BOX_H);

  // Final colour choice: blanking forces black, a lit glyph pixel wins over
  // the background otherwise.
  function automatic logic [RGB_W-1:0] compose_pixel(input logic             blank,
                                                     input logic             show_text,
                                                     input logic [RGB_W-1:0] bg);
    if (blank)     return '0;
    if (show_text) return TEXT_RGB;
    return bg;
  endfunction

  // ---------------------------------------------------------------------
  // Control: sticky game-over flag, frame-aligned arming, blink counter
  // ---------------------------------------------------------------------
  logic                   over_q;
  logic                   vsync_prev;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   vsync_rise;

  assign vsync_rise = vsync_in & ~vsync_prev;

  // Latch collisions until restart; arm/disarm the overlay only at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      over_q         <= 1'b0;
      vsync_prev     <= 1'b0;
      overlay_active <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (restart)        over_q <= 1'b0;
      else if (game_over) over_q <= 1'b1;
      if (vsync_rise) overlay_active <= over_q;
      if (!overlay_active) frame_cnt <= '0;
      else if (vsync_rise) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: box test and font addressing from the incoming position
  // ---------------------------------------------------------------------
  logic [COORD_W-1:0]     dx;
  logic [COORD_W-1:0]     dy;
  logic [COORD_W-1:0]     char_idx;
  logic                   in_box;
  logic [3:0]             font_row;
  logic [2:0]             font_col;
  char_code_t             char_code;
  logic [FONT_ADDR_W-1:0] rom_addr;
  vga_timing_t            timing_in;
  logic                   unused_bits;

  // Offsets wrap for pixels left of or above the box; in_box masks those.
  assign dx       = hcount_in - X_LO;
  assign dy       = vcount_in - Y_LO;
  assign in_box   = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                    (vcount_in >= Y_LO) && (vcount_in < Y_HI);
  assign char_idx = dx >> 4;
  assign font_row = dy[4:1];
  assign font_col = dx[3:1];
  assign rom_addr = {char_code, font_row};

  // The LSBs are consumed by the 2x scaling and the upper dy bits fall
  // outside the box height.
  assign unused_bits = &{1'b0, dx[0], dy[0], dy[10:5]};

  assign timing_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};

  // Map the cell index onto the message text; out-of-range reads as a space.
  always_comb begin
    char_code = 7'h20;
    case (char_idx)
      11'd0:   char_code = TEXT_CODES[0];
      11'd1:   char_code = TEXT_CODES[1];
      11'd2:   char_code = TEXT_CODES[2];
      11'd3:   char_code = TEXT_CODES[3];
      11'd4:   char_code = TEXT_CODES[4];
      11'd5:   char_code = TEXT_CODES[5];
      11'd6:   char_code = TEXT_CODES[6];
      11'd7:   char_code = TEXT_CODES[7];
      11'd8:   char_code = TEXT_CODES[8];
      default: char_code = 7'h20;
    endcase
  end

  vga_timing_t      timing_p1;
  logic [RGB_W-1:0] rgb_p1;
  logic [2:0]       font_col_p1;
  logic             in_box_p1;

  // Carry timing, background colour and glyph column alongside the ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timing_p1   <= '0;
      rgb_p1      <= '0;
      font_col_p1 <= '0;
      in_box_p1   <= 1'b0;
    end else begin
      timing_p1   <= timing_in;
      rgb_p1      <= rgb_in;
      font_col_p1 <= font_col;
      in_box_p1   <= in_box;
    end
  end

  logic [FONT_DATA_W-1:0] rom_data_p1;

  game_over_font_rom u_font_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (rom_addr),
    .data (rom_data_p1)
  );

  // ---------------------------------------------------------------------
  // Stage 2: glyph pixel select and compositing
  // ---------------------------------------------------------------------
  logic             glyph_px;
  logic             show_text;
  logic             blank_p1;
  logic [RGB_W-1:0] rgb_next;

  assign glyph_px  = rom_data_p1[3'd7 - font_col_p1];
  assign show_text = overlay_active & ~frame_cnt[BLINK_BIT] & in_box_p1 & glyph_px;
  assign blank_p1  = timing_p1.hblnk | timing_p1.vblnk;
  assign rgb_next  = compose_pixel(blank_p1, show_text, rgb_p1);

  vga_timing_t      timing_p2;
  logic [RGB_W-1:0] rgb_p2;

  // Output register: timing and composited colour leave together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timing_p2 <= '0;
      rgb_p2    <= '0;
    end else begin
      timing_p2 <= timing_p1;
      rgb_p2    <= rgb_next;
    end
  end

  assign hcount_out = timing_p2.hcount;
  assign vcount_out = timing_p2.vcount;
  assign hsync_out  = timing_p2.hsync;
  assign hblnk_out  = timing_p2.hblnk;
  assign vsync_out  = timing_p2.vsync;
  assign vblnk_out  = timing_p2.vblnk;
  assign rgb_out    = rgb_p2;

endmodule

// File: tb/tb_game_over_overlay.sv
// Bench for game_over_overlay: compact frames around the text box, a
// reference model producing expected pixels into a two-deep scoreboard.
module tb_game_over_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        game_over, restart;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        overlay_active;

  game_over_overlay dut (
    .clk            (clk),
    .rst            (rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hsync_in       (hsync_in),
    .hblnk_in       (hblnk_in),
    .vsync_in       (vsync_in),
    .vblnk_in       (vblnk_in),
    .rgb_in         (rgb_in),
    .game_over      (game_over),
    .restart        (restart),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .hsync_out      (hsync_out),
    .hblnk_out      (hblnk_out),
    .vsync_out      (vsync_out),
    .vblnk_out      (vblnk_out),
    .rgb_out        (rgb_out),
    .overlay_active (overlay_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [3:0]  sync;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   red_cnt = 0;
  bit   rgb_mode = 1'b0;   // 1: constant 12'h0F0 background
  bit   m_over = 1'b0;
  bit   m_ov   = 1'b0;
  int   m_cnt  = 0;
  bit   m_vprev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8x8 bitmaps for each message position, top row in the high byte.
  function automatic logic [63:0] font_of(input int ci);
    case (ci)
      0:       return 64'h3C66C0C0CE663E00; // G
      1:       return 64'h3078CCCCFCCCCC00; // A
      2:       return 64'hC6EEFEFED6C6C600; // M
      3, 7:    return 64'hFE6268786862FE00; // E
      5:       return 64'h386CC6C6C66C3800; // O
      6:       return 64'hCCCCCCCCCC783000; // V
      8:       return 64'hFC66667C6C66E600; // R
      default: return 64'h0;                // space
    endcase
  endfunction

  function automatic bit text_bit(input int h, input int v);
    int dx, dy;
    logic [63:0] bm;
    if (!(h >= 440 && h < 584 && v >= 368 && v < 400)) return 1'b0;
    dx = h - 440;
    dy = v - 368;
    bm = font_of(dx / 16);
    return bm[63 - 8 * (dy / 4) - (dx % 16) / 2];
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_hcount"}, 32'(hcount_out), 32'd0);
    chk({tag, "_vcount"}, 32'(vcount_out), 32'd0);
    chk({tag, "_sync"}, 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'd0);
    chk({tag, "_ov"}, 32'(overlay_active), 32'd0);
  endtask

  task automatic step(input int h, input int v, input bit hs, input bit hb,
                      input bit vs, input bit vb, input bit go, input bit rs);
    exp_t e;
    logic [11:0] px;
    bit rise;
    int ncnt;
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("hcount", 32'(hcount_out), 32'(e.h));
      chk("vcount", 32'(vcount_out), 32'(e.v));
      chk("sync", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'(e.sync));
      chk("rgb", 32'(rgb_out), 32'(e.rgb));
      if (rgb_out == 12'hF00) red_cnt++;
    end
    chk("overlay_active", 32'(overlay_active), 32'(m_ov));
    px = rgb_mode ? 12'h0F0 : {4'h0, 4'(h), 4'(v)};
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb;
    rgb_in = px; game_over = go; restart = rs;
    e.h = 11'(h); e.v = 11'(v); e.sync = {hs, hb, vs, vb};
    if (hb || vb)                                  e.rgb = 12'h000;
    else if (m_ov && m_cnt < 32 && text_bit(h, v)) e.rgb = 12'hF00;
    else                                           e.rgb = px;
    q.push_back(e);
    rise = vs && !m_vprev;
    ncnt = !m_ov ? 0 : (rise ? (m_cnt + 1) % 64 : m_cnt);
    if (rise) m_ov = m_over;
    m_cnt = ncnt;
    if (rs) m_over = 1'b0; else if (go) m_over = 1'b1;
    m_vprev = vs;
  endtask

  // Asynchronous reset at the current negedge, held for three cycles.
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    #1;
    chk_zero("rst_now");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hcount_in = 11'($urandom_range(0, 2047)); vcount_in = 11'($urandom_range(0, 2047));
      hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
      rgb_in = 12'h0F0; game_over = 1'b0; restart = 1'b0;
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    m_over = 1'b0; m_ov = 1'b0; m_cnt = 0; m_vprev = 1'b0;
  endtask

  // ev_kind: 0 none, 1 game_over pulse, 2 game_over+restart, 3 reset.
  task automatic frame(input int v0, input int v1, input int h0, input int h1,
                       input int ev_v, input int ev_h, input int ev_kind);
    bit go, rs;
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) begin
        go = 1'b0; rs = 1'b0;
        if (v == ev_v && h == ev_h) begin
          if (ev_kind == 3) do_reset();
          go = (ev_kind == 1) || (ev_kind == 2);
          rs = (ev_kind == 2);
        end
        step(h, v, 1'b0, 1'b0, 1'b0, 1'b0, go, rs);
      end
      for (int i = 0; i < 4; i++) step(1030 + i, v, (i == 1) || (i == 2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(0, 780 + i, 1'b0, 1'b0, (i >= 2) && (i <= 5), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
    vsync_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0; game_over = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Plain pass-through of a constant green field.
    rgb_mode = 1'b1;
    red_cnt = 0;
    frame(366, 401, 438, 585, -1, -1, 0);
    chk("passthru_red", 32'(red_cnt), 32'd0);

    // Single-cycle collision mid-frame: no text this frame, armed after vsync.
    rgb_mode = 1'b0;
    red_cnt = 0;
    frame(366, 401, 438, 585, 380, 500, 1);
    chk("pulse_frame_red", 32'(red_cnt), 32'd0);
    chk("armed_after_vsync", 32'(overlay_active), 32'd1);

    // Frame 0 of the blink cycle with box edges included.
    red_cnt = 0;
    frame(366, 401, 438, 585, -1, -1, 0);
    chk("frame0_text", 32'(red_cnt > 0), 32'd1);

    // Blink: frames 1..63 then wrap to 0 at frame 64.
    for (int f = 1; f <= 64; f++) begin
      red_cnt = 0;
      frame(368, 371, 438, 470, -1, -1, 0);
      chk($sformatf("blink_f%0d", f), 32'(red_cnt > 0), 32'((f % 64) < 32));
    end

    // Collision and restart together clear the flag; disarmed at next vsync.
    frame(368, 371, 438, 470, 368, 460, 2);
    chk("cleared_after_vsync", 32'(overlay_active), 32'd0);

    // Re-arm, then reset in the middle of a visible frame.
    frame(368, 371, 438, 470, 368, 460, 1);
    chk("rearmed", 32'(overlay_active), 32'd1);
    frame(366, 401, 438, 585, 370, 450, 3);
    red_cnt = 0;
    frame(366, 401, 438, 585, -1, -1, 0);
    chk("post_reset_red", 32'(red_cnt), 32'd0);
    chk("post_reset_ov", 32'(overlay_active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_over_overlay.md
GAME_OVER_OVERLAY -- requirements
Module: game_over_overlay

Interface
REQ-001 clk  in  1  pixel clock, all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 hcount_in, vcount_in  in  11 each  pixel position from upstream VGA stage.
REQ-004 hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing from upstream.
REQ-005 rgb_in  in  12  upstream pixel colour, 4:4:4.
REQ-006 game_over  in  1  collision flag from border-check stage, level, may assert for single cycles.
REQ-007 restart  in  1  synchronous pulse that clears the game-over condition.
REQ-008 hcount_out, vcount_out  out  11 each; hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each; all are the inputs delayed exactly 2 clk.
REQ-009 rgb_out  out  12  composited pixel, aligned with the delayed timing.
REQ-010 overlay_active  out  1  high while the overlay is armed for the current frame.
REQ-011 Parameters: TEXT_X default 440 (left edge); TEXT_Y default 368 (top edge); TEXT_RGB default 12'hF00 (glyph colour); BLINK_BIT default 5 (frame-counter bit used for blinking).

Function
REQ-012 Sticky flag over_q: set on any cycle with game_over=1; cleared on a cycle with restart=1; restart wins when both are high.
REQ-013 overlay_active loads over_q only on the rising edge of vsync_in, so the overlay never starts or stops mid-frame.
REQ-014 6-bit frame counter: increments on each vsync_in rising edge while overlay_active=1, wraps 63->0; held at 0 while overlay_active=0.
REQ-015 Text "GAME OVER": 9 characters (ASCII 0x47,0x41,0x4D,0x45,0x20,0x4F,0x56,0x45,0x52); 8x16 font scaled 2x, giving 16x32 pixels per cell and a 144x32 box at (TEXT_X,TEXT_Y).
REQ-016 In-box test: TEXT_X <= hcount < TEXT_X+144 and TEXT_Y <= vcount < TEXT_Y+32.
REQ-017 Stage 1 (cycle N): char index = (hcount-TEXT_X)>>4; font row = (vcount-TEXT_Y)>>1; column = ((hcount-TEXT_X)>>1)&7. ROM address {code[6:0],row[3:0]} is presented; timing, rgb_in, column and in-box are registered.
REQ-018 Stage 2 (cycle N+1): pixel bit = rom_data[7-column]; rgb_out is registered.
REQ-019 rgb_out = 0 when delayed hblnk or vblnk is 1; else TEXT_RGB when overlay_active, frame_cnt[BLINK_BIT]=0, in-box and pixel bit=1; else delayed rgb_in.
REQ-020 Outside the box, the ROM address is don't-care; in-box gating alone suppresses glyphs.
REQ-021 The 2-cycle latency is fixed, independent of overlay_active.
REQ-022 Subtractions use 11-bit unsigned arithmetic and are only evaluated as meaningful when in-box=1; no wrap artefacts may reach rgb_out.

Reset
REQ-023 While rst=1: all outputs 0; over_q, overlay_active, frame counter and pipeline registers 0.
REQ-024 Asserting rst mid-frame forces rgb_out=0 immediately; after release, the overlay stays inactive until over_q is set and a vsync rising edge occurs.

Structure
REQ-025 Shared package/header holds HOR_PIX=1024, VER_PIX=768, CHAR_W=8, CHAR_H=16, SCALE=2 and the 9-entry text code table.
REQ-026 One sub-module, game_over_font_rom: synchronous 1-cycle-read ROM, 11-bit address, 8-bit data, bit 7 = leftmost pixel.
REQ-027 Text code selection is a combinational case on char index 0..8 inside game_over_overlay.

Verification
REQ-028 rgb_in=12'h0F0, game_over=0 for a full frame -> rgb_out=12'h0F0 in the active area, 0 in blanking, timing equal to the input delayed 2 cycles.
REQ-029 1-cycle game_over pulse mid-frame -> no change in that frame; overlay_active=1 after the next vsync rise; pixel (440,368) region shows the 'G' glyph in 12'hF00.
REQ-030 Overlay active for 64 frames -> glyphs visible in frames 0-31 and suppressed in frames 32-63 (BLINK_BIT=5); counter wraps to 0 at frame 64.
REQ-031 game_over and restart high in the same cycle -> over_q=0; overlay_active=0 after the next vsync rise.
REQ-032 rst asserted mid-frame while overlay is active -> all outputs 0 while rst=1; after release, rgb_out passes rgb_in with no text.
REQ-033 Pixels at hcount 439/584 and vcount 367/400 (just outside the box) -> rgb_out equals delayed rgb_in even when overlay is active.
